aurora_idle_sequencer: RTL and testbench
========================================

Name: aurora_idle_sequencer

Overview:
Multi-lane idle/clock-compensation sequencer for the Aurora 8b/10b TX path. It generalises the single-lane idle generator in three ways: K/R selection runs per lane; the /A/ gap is a parametrised random range and /A/ is emitted lane-aligned; a clock-compensation (/CC/) scheduler is optionally built in. It sits between the TX framer (which drives send_idle) and the per-lane symbol encoders.

Parameters:
LANES, 2, number of lanes (1..8)
A_MIN, 16, minimum idle cycles between /A/ on all lanes
A_RANGE_LOG2, 4, random extra gap width; gap = A_MIN + rnd[A_RANGE_LOG2-1:0]
LFSR_SEED, 16'hACE1, LFSR reset value (must be non-zero)
CC_PERIOD, 5000, cycles between /CC/ sequence starts
CC_LEN, 6, cycles per /CC/ sequence

Ports:
clk  in  1  clock
rst  in  1  reset; one clock; reset is asynchronous and active-high
send_idle  in  1  framer requests idle in the current cycle
send_k  out  LANES  lane i sends /K/
send_a  out  LANES  lane i sends /A/ (always all-ones or all-zeros)
send_r  out  LANES  lane i sends /R/
send_cc  out  1  all lanes send /CC/
tx_stall  out  1  framer must not present data this cycle

Behaviour:
- Reset (async assert, sync release): LFSR=LFSR_SEED, A counter=A_MIN, idle_q=0, CC timer=CC_PERIOD-1, cc_cnt=0; all outputs 0.
- LFSR: 16-bit Fibonacci, x^16+x^14+x^13+x^11+1, shifts every cycle, including during CC. Lane i random bit = lfsr[i]. Gap random field = lfsr[15 -: A_RANGE_LOG2].
- idle_q <= send_idle & !cc_active, registered.
- Outputs are combinational from the current state and send_idle. At most one of send_k[i], send_a[i], send_r[i] is set per lane.
- Priority, evaluated each cycle:
  1. cc_active: send_cc=1; send_k, send_a and send_r are all 0.
  2. send_idle & !idle_q (first idle cycle, including the first after CC): send_k = all ones.
  3. send_idle & idle_q & a_zero: send_a = all ones. A counter reloads A_MIN + rnd.
  4. send_idle & idle_q & !a_zero: per lane, send_k[i]=lfsr[i] and send_r[i]=!lfsr[i].
  5. Otherwise all outputs are 0.
- A counter:
  - Decrements when send_idle & !cc_active & !a_zero.
  - Saturates at 0 and holds while not idle. A pending /A/ goes out on the next non-first idle cycle.
  - Frozen during CC.
  - Counter width = clog2(A_MIN + 2^A_RANGE_LOG2).
- Gap counting: A_MIN=16 means at least 16 non-A idle cycles between consecutive /A/ cycles in continuous idle.
- Simultaneous events: a_zero on a first idle cycle gives /K/ (rule 2 wins); /A/ follows on the next idle cycle.
- Reset mid-CC or mid-gap: everything returns to reset values immediately, with no partial CC completion.

Optional Feature:
Macro AURORA_IDLE_CC_EN.
- Defined:
  - CC timer counts down each cycle. At 0 it reloads CC_PERIOD-1 and sets cc_start.
  - Next cycle cc_active=1 for exactly CC_LEN cycles (cc_cnt CC_LEN-1..0).
  - tx_stall = cc_start | cc_active, i.e. it asserts one cycle before the first /CC/.
  - CC is unconditional and overrides data and idle.
  - Sequence starts are exactly CC_PERIOD cycles apart.
  - Requires CC_PERIOD > CC_LEN+1.
- Undefined: send_cc=0, tx_stall=0, cc_active=0; no CC timer logic synthesised.

Test Plan:
- Reset then send_idle=1 constant, LANES=2: cycle 0 send_k=2'b11; no /A/ before 17th idle cycle; every /A/ cycle has send_a=2'b11; /A/-to-/A/ spacing in [17,32] cycles.
- Continuous idle, 2000 cycles: per lane, send_k^send_r=1 on every non-A cycle; onehot0 of {k,a,r} per lane; both K and R seen on each lane; lanes differ on some cycle.
- send_idle toggles 1,0,1,0: each idle cycle is first-idle and gives send_k=all ones; A counter does not expire before 16 idle cycles accumulate, then the next non-first idle gives /A/.
- AURORA_IDLE_CC_EN, CC_PERIOD=64, CC_LEN=6, idle throughout:
  - tx_stall rises at cycle 63 and send_cc is high for cycles 64..69.
  - Cycle 70 gives send_k=all ones.
  - The next send_cc rises at cycle 128.
- Assert rst for 1 cycle during send_cc (async, mid-clock): all outputs 0 immediately; after release, the first idle cycle gives /K/; the CC timer restarts from CC_PERIOD-1.
- Without macro: 20000 idle cycles with send_cc=0 and tx_stall=0 throughout; behaviour otherwise identical to the first test.

Source files
------------

// File: rtl/aurora_idle_sequencer.sv
// Multi-lane Aurora TX idle / clock-compensation sequencer: per-lane /K/-/R/ selection,
// lane-aligned /A/ with a random gap, optional /CC/ scheduler under AURORA_IDLE_CC_EN.

module aurora_idle_lane (
    input  logic k_all,
    input  logic a_all,
    input  logic rnd_en,
    input  logic rnd,
    output logic k,
    output logic a,
    output logic r
);
    assign k = k_all | (rnd_en & rnd);
    assign a = a_all;
    assign r = rnd_en & ~rnd;
endmodule

module aurora_idle_sequencer #(
    parameter int          LANES        = 2,
    parameter int          A_MIN        = 16,
    parameter int          A_RANGE_LOG2 = 4,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    parameter int          CC_PERIOD    = 5000,
    parameter int          CC_LEN       = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             send_idle,
    output logic [LANES-1:0] send_k,
    output logic [LANES-1:0] send_a,
    output logic [LANES-1:0] send_r,
    output logic             send_cc,
    output logic             tx_stall
);
    localparam int AW = $clog2(A_MIN + (1 << A_RANGE_LOG2));

    if (CC_PERIOD <= CC_LEN + 1 || LFSR_SEED == 16'h0000 || LANES < 1 || LANES > 8) begin : g_param_err
        $error("aurora_idle_sequencer: illegal parameter combination");
    end

    logic [15:0]   lfsr;
    logic [AW-1:0] a_cnt;
    logic          idle_q;
    logic          a_zero;
    logic          idle_ok;
    logic          cc_active;
    logic          stall_raw;
    logic          k_all, a_all, rnd_en, cc_out;

    // x^16+x^14+x^13+x^11+1, right-shifting Fibonacci form
    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr <= LFSR_SEED;
        else     lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end

    assign a_zero  = (a_cnt == '0);
    assign idle_ok = send_idle & ~cc_active;

    // Counter parks at zero outside idle so the pending /A/ leaves on the next non-first idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_cnt  <= AW'(A_MIN);
            idle_q <= 1'b0;
        end else begin
            idle_q <= idle_ok;
            if (idle_ok) begin
                if (!a_zero)
                    a_cnt <= a_cnt - 1'b1;
                else if (idle_q)
                    a_cnt <= AW'(A_MIN) + AW'(lfsr[15 -: A_RANGE_LOG2]);
            end
        end
    end

`ifdef AURORA_IDLE_CC_EN
    localparam int TW = $clog2(CC_PERIOD);
    localparam int LW = (CC_LEN > 1) ? $clog2(CC_LEN) : 1;

    typedef enum logic {CC_OFF, CC_RUN} cc_state_t;

    cc_state_t       cc_state, cc_state_nxt;
    logic [TW-1:0]   cc_timer;
    logic [LW-1:0]   cc_cnt, cc_cnt_nxt;
    logic            cc_start;

    assign cc_start = (cc_timer == '0);

    // Free-running period timer; never paused, so starts stay exactly CC_PERIOD apart.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           cc_timer <= TW'(CC_PERIOD - 1);
        else if (cc_start) cc_timer <= TW'(CC_PERIOD - 1);
        else               cc_timer <= cc_timer - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cc_state <= CC_OFF;
            cc_cnt   <= '0;
        end else begin
            cc_state <= cc_state_nxt;
            cc_cnt   <= cc_cnt_nxt;
        end
    end

    always_comb begin
        cc_state_nxt = cc_state;
        cc_cnt_nxt   = cc_cnt;
        case (cc_state)
            CC_OFF: begin
                if (cc_start) begin
                    cc_state_nxt = CC_RUN;
                    cc_cnt_nxt   = LW'(CC_LEN - 1);
                end
            end
            CC_RUN: begin
                if (cc_cnt == '0) cc_state_nxt = CC_OFF;
                else              cc_cnt_nxt   = cc_cnt - 1'b1;
            end
            default: cc_state_nxt = CC_OFF;
        endcase
    end

    assign cc_active = (cc_state == CC_RUN);
    assign stall_raw = cc_start | cc_active;
`else
    assign cc_active = 1'b0;
    assign stall_raw = 1'b0;
`endif

    // Output priority: CC, first idle /K/, /A/, per-lane random /K/-/R/.
    always_comb begin
        cc_out = 1'b0;
        k_all  = 1'b0;
        a_all  = 1'b0;
        rnd_en = 1'b0;
        if (!rst) begin
            if (cc_active)                 cc_out = 1'b1;
            else if (send_idle && !idle_q) k_all  = 1'b1;
            else if (send_idle && a_zero)  a_all  = 1'b1;
            else if (send_idle)            rnd_en = 1'b1;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        aurora_idle_lane u_lane (
            .k_all (k_all),
            .a_all (a_all),
            .rnd_en(rnd_en),
            .rnd   (lfsr[i]),
            .k     (send_k[i]),
            .a     (send_a[i]),
            .r     (send_r[i])
        );
    end

    assign send_cc  = cc_out;
    assign tx_stall = stall_raw & ~rst;
endmodule

// File: tb/tb_aurora_idle_sequencer.sv
// Scoreboarded bench for aurora_idle_sequencer; CC scenarios build only with AURORA_IDLE_CC_EN.
module tb_aurora_idle_sequencer;
    localparam int          LANES        = 2;
    localparam int          A_MIN        = 16;
    localparam int          A_RANGE_LOG2 = 4;
    localparam logic [15:0] SEED         = 16'hACE1;
    localparam int          CC_PERIOD    = 64;
    localparam int          CC_LEN       = 6;
`ifdef AURORA_IDLE_CC_EN
    localparam bit CC_EN  = 1'b1;
    localparam int N_IDLE = 2000;
    localparam int EXP_CC = 186;   // 31 sequences (starts 64..1984) x 6 cycles
`else
    localparam bit CC_EN  = 1'b0;
    localparam int N_IDLE = 20000;
    localparam int EXP_CC = 0;
`endif
    localparam logic [LANES-1:0] ALL1 = {LANES{1'b1}};

    logic clk = 1'b0;
    logic rst, send_idle;
    logic [LANES-1:0] send_k, send_a, send_r;
    logic send_cc, tx_stall;

    always #5 clk = ~clk;

    aurora_idle_sequencer #(
        .LANES(LANES), .A_MIN(A_MIN), .A_RANGE_LOG2(A_RANGE_LOG2),
        .LFSR_SEED(SEED), .CC_PERIOD(CC_PERIOD), .CC_LEN(CC_LEN)
    ) dut (
        .clk(clk), .rst(rst), .send_idle(send_idle),
        .send_k(send_k), .send_a(send_a), .send_r(send_r),
        .send_cc(send_cc), .tx_stall(tx_stall)
    );

    typedef struct packed {
        logic [LANES-1:0] k;
        logic [LANES-1:0] a;
        logic [LANES-1:0] r;
        logic             cc;
        logic             stall;
    } obs_t;

    obs_t exp_q[$];
    obs_t got;
    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // reference model state
    logic [15:0] m_lfsr;
    int          m_acnt;
    bit          m_idle_q;
    int          m_timer;
    int          m_cc_left;

    task automatic model_reset();
        m_lfsr = SEED; m_acnt = A_MIN; m_idle_q = 1'b0;
        m_timer = CC_PERIOD - 1; m_cc_left = 0;
    endtask

    function automatic obs_t model_out(input bit idle);
        obs_t o;
        bit act;
        o = '0;
        act = CC_EN && (m_cc_left > 0);
        o.stall = CC_EN && (act || m_timer == 0);
        if (act) o.cc = 1'b1;
        else if (idle && !m_idle_q) o.k = ALL1;
        else if (idle && m_acnt == 0) o.a = ALL1;
        else if (idle) begin
            o.k = m_lfsr[LANES-1:0];
            o.r = ~m_lfsr[LANES-1:0];
        end
        return o;
    endfunction

    task automatic model_advance(input bit idle);
        bit act;
        act = CC_EN && (m_cc_left > 0);
        if (idle && !act) begin
            if (m_acnt != 0) m_acnt--;
            else if (m_idle_q) m_acnt = A_MIN + int'(m_lfsr[15 -: A_RANGE_LOG2]);
        end
        m_idle_q = idle && !act;
        if (CC_EN) begin
            if (act) m_cc_left--;
            if (m_timer == 0) begin m_timer = CC_PERIOD - 1; m_cc_left = CC_LEN; end
            else m_timer--;
        end
        m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    endtask

    // One clock: drive at negedge, push expectation, sample 1ns later, pop and compare.
    task automatic step(input bit idle, input string tag);
        obs_t e;
        send_idle = idle;
        exp_q.push_back(model_out(idle));
        model_advance(idle);
        #1;
        got = {send_k, send_a, send_r, send_cc, tx_stall};
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL %s cycle %0d: got k=%b a=%b r=%b cc=%b stall=%b want k=%b a=%b r=%b cc=%b stall=%b",
                     tag, cyc, got.k, got.a, got.r, got.cc, got.stall, e.k, e.a, e.r, e.cc, e.stall);
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; send_idle = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        cyc = 0;
    endtask

    function automatic bit lane_ok(input obs_t o);
        if (o.a != '0 && o.a != ALL1) return 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (int'(o.k[i]) + int'(o.a[i]) + int'(o.r[i]) > 1) return 1'b0;
            if (!o.cc && !o.a[i] && ((o.k[i] ^ o.r[i]) != 1'b1)) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic test_reset();
        rst = 1'b1; send_idle = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        got = {send_k, send_a, send_r, send_cc, tx_stall};
        checks++;
        if (got !== '0) begin errors++; $display("FAIL reset_outputs: got %b want 0", got); end
        @(negedge clk);
        rst = 1'b0; model_reset(); cyc = 0;
        step(1'b1, "reset_first");
        checks++;
        if (got.k !== ALL1) begin errors++; $display("FAIL reset_first_k: got %b want %b", got.k, ALL1); end
    endtask

    task automatic test_const_idle();
        int last_a = -1;
        int first_a = -1;
        int n_cc = 0;
        bit cc_between = 1'b0;
        bit differ = 1'b0;
        bit seen_k[LANES];
        bit seen_r[LANES];
        for (int i = 0; i < LANES; i++) begin seen_k[i] = 1'b0; seen_r[i] = 1'b0; end
        do_reset();
        for (int c = 0; c < N_IDLE; c++) begin
            step(1'b1, "const_idle");
            checks++;
            if (!lane_ok(got)) begin
                errors++;
                $display("FAIL lane_rules cycle %0d: got k=%b a=%b r=%b", c, got.k, got.a, got.r);
            end
            if (got.cc) begin n_cc++; cc_between = 1'b1; end
            if (got.a != '0) begin
                if (first_a < 0) first_a = c;
                if (last_a >= 0 && !cc_between) begin
                    checks++;
                    if (c - last_a < 17 || c - last_a > 32) begin
                        errors++;
                        $display("FAIL a_spacing cycle %0d: got %0d want 17..32", c, c - last_a);
                    end
                end
                last_a = c; cc_between = 1'b0;
            end
            for (int i = 0; i < LANES; i++) begin
                if (got.k[i]) seen_k[i] = 1'b1;
                if (got.r[i]) seen_r[i] = 1'b1;
                if (got.r != '0 && got.k[i] != got.k[0]) differ = 1'b1;
            end
`ifdef AURORA_IDLE_CC_EN
            if (c == 63) begin
                checks++;
                if (got.stall !== 1'b1 || got.cc !== 1'b0) begin
                    errors++; $display("FAIL cc_stall_63: got stall=%b cc=%b want 1 0", got.stall, got.cc);
                end
            end
            if (c >= 64 && c <= 69) begin
                checks++;
                if (got.cc !== 1'b1) begin errors++; $display("FAIL cc_window cycle %0d: got %b want 1", c, got.cc); end
            end
            if (c == 70) begin
                checks++;
                if (got.k !== ALL1) begin errors++; $display("FAIL cc_after_k: got %b want %b", got.k, ALL1); end
            end
            if (c == 127 || c == 128) begin
                checks++;
                if (got.cc !== (c == 128)) begin
                    errors++; $display("FAIL cc_second cycle %0d: got %b want %b", c, got.cc, c == 128);
                end
            end
`endif
        end
        checks++;
        if (first_a != 16) begin errors++; $display("FAIL first_a: got %0d want 16", first_a); end
        checks++;
        if (n_cc != EXP_CC) begin errors++; $display("FAIL cc_count: got %0d want %0d", n_cc, EXP_CC); end
        for (int i = 0; i < LANES; i++) begin
            checks++;
            if (!(seen_k[i] && seen_r[i])) begin
                errors++; $display("FAIL lane%0d_k_and_r: got k=%b r=%b want 1 1", i, seen_k[i], seen_r[i]);
            end
        end
        checks++;
        if (!differ) begin errors++; $display("FAIL lanes_differ: got 0 want 1"); end
    endtask

    // pre idle pulses at alternate cycles, then consecutive idles; want_a marks the /A/ slot
    task automatic toggle_run(input int pulses, input int tail, input string tag);
        do_reset();
        for (int c = 0; c < 2 * pulses; c++) begin
            step(c % 2 == 0, tag);
            if (c % 2 == 0) begin
                checks++;
                if (got.k !== ALL1 || got.a !== '0) begin
                    errors++; $display("FAIL %s_first_k cycle %0d: got k=%b a=%b want %b 0", tag, c, got.k, got.a, ALL1);
                end
            end
        end
        for (int t = 0; t < tail; t++) begin
            step(1'b1, tag);
            checks++;
            if (got.a !== ((t == tail - 1) ? ALL1 : '0)) begin
                errors++; $display("FAIL %s_a slot %0d: got %b want %b", tag, t, got.a, (t == tail - 1) ? ALL1 : '0);
            end
        end
    endtask

    task automatic test_toggle();
        toggle_run(16, 2, "toggle16");
        toggle_run(14, 3, "toggle14");
    endtask

    task automatic test_reset_mid();
        logic pre_cc;
        do_reset();
        repeat (66) step(1'b1, "mid_pre");
        send_idle = 1'b1;
        #1 pre_cc = send_cc;
        #1 rst = 1'b1;
        #1;
        got = {send_k, send_a, send_r, send_cc, tx_stall};
        checks++;
        if (got !== '0 || pre_cc !== CC_EN) begin
            errors++; $display("FAIL mid_reset: got %b pre_cc=%b want 0 %b", got, pre_cc, CC_EN);
        end
        @(negedge clk);
        rst = 1'b0; model_reset(); cyc = 0;
        for (int c = 0; c < 140; c++) begin
            step(1'b1, "mid_post");
            if (c == 0) begin
                checks++;
                if (got.k !== ALL1) begin errors++; $display("FAIL mid_post_k: got %b want %b", got.k, ALL1); end
            end
`ifdef AURORA_IDLE_CC_EN
            if (c == 63 || c == 64) begin
                checks++;
                if (got.stall !== 1'b1 || got.cc !== (c == 64)) begin
                    errors++; $display("FAIL mid_post_cc cycle %0d: got stall=%b cc=%b", c, got.stall, got.cc);
                end
            end
`endif
        end
    endtask

    initial begin
        rst = 1'b1; send_idle = 1'b0;
        @(negedge clk);
        test_reset();
        test_const_idle();
        test_toggle();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: bench did not complete within time limit");
        $fatal(1, "timeout");
    end
endmodule
